hvac_actuator_scheduler: RTL and testbench

Sequences the single heater relay and single cooler relay of the greenhouse from the heat/cool requests raised by the hysteresis temperature controller, enforcing mutual exclusion, minimum on-time and minimum rest-time between actuations. It also owns the cooldown/heatup threshold registers that feed that controller, accepting clamped configuration writes over a valid/ready handshake. Sits between the temperature controller and the relay drivers.

---
 rtl/greenhouse_pkg.sv | 41 ++++
 rtl/tick_timer.sv | 35 +++
 rtl/hvac_actuator_scheduler.sv | 127 ++++++++++++
 tb/tb_hvac_actuator_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/greenhouse_pkg.sv
// rtl/greenhouse_pkg.sv - shared greenhouse climate types, threshold defaults and clamp bounds
//
// Shared by the actuator scheduler and the hysteresis temperature controller.
// Contents:
//   sched_state_t      actuator sequencing states
//   *_DEFAULT          threshold reset values
//   *_MIN / *_MAX      legal threshold window; configuration writes are clamped into it
//   clamp_u8()         saturate an unsigned byte into [lo, hi]
package greenhouse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COOL = 2'd1,
      HEAT = 2'd2,
      REST = 2'd3
   } sched_state_t;

   localparam logic [7:0] COOLDOWN_DEFAULT = 8'd95;
   localparam logic [7:0] HEATUP_DEFAULT   = 8'd60;

   localparam logic [7:0] COOLDOWN_MIN = 8'd90;
   localparam logic [7:0] COOLDOWN_MAX = 8'd120;
   localparam logic [7:0] HEATUP_MIN   = 8'd10;
   localparam logic [7:0] HEATUP_MAX   = 8'd80;

   // Out-of-range values snap to the nearest bound instead of being rejected.
   function automatic logic [7:0] clamp_u8(input logic [7:0] value,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
      logic [7:0] result;
      if (value < lo) begin
         result = lo;
      end else if (value > hi) begin
         result = hi;
      end else begin
         result = value;
      end
      return result;
   endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - loadable saturating down-counter advanced by a tick strobe
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (count -> 0)
//   tick         timebase strobe; count decrements only when high
//   load         load load_val this cycle (takes priority over tick)
//   load_val     value to load
//   zero         count is zero
module tick_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && (count != '0)) begin
         // Saturates at zero; never wraps.
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hvac_actuator_scheduler.sv
// rtl/hvac_actuator_scheduler.sv - heater/cooler relay sequencer with threshold config registers
//
// Turns heat/cool requests into mutually exclusive relay drives with a minimum
// on-time and a minimum rest-time, and holds the cooldown/heatup thresholds
// used by the temperature controller.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   tick                   timebase strobe for the on/rest timers
//   cool_req, heat_req     requests from the temperature controller
//   cfg_valid/cfg_ready    config write handshake (accepted only while idle)
//   cfg_sel, cfg_data      0 = cooldown, 1 = heatup; unsigned value, clamped
//   cooldown_th, heatup_th active thresholds
//   cooler_on, heater_on   relay drives, never both high
//   conflict               sticky flag: both requests seen high together
module hvac_actuator_scheduler
   import greenhouse_pkg::*;
#(
   parameter int MIN_ON  = 8,
   parameter int MIN_OFF = 4,
   parameter int CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       cool_req,
   input  logic       heat_req,
   input  logic       cfg_valid,
   input  logic       cfg_sel,
   input  logic [7:0] cfg_data,
   output logic       cfg_ready,
   output logic [7:0] cooldown_th,
   output logic [7:0] heatup_th,
   output logic       cooler_on,
   output logic       heater_on,
   output logic       conflict
);

   localparam logic [CNT_W-1:0] ON_VAL  = CNT_W'(MIN_ON);
   localparam logic [CNT_W-1:0] OFF_VAL = CNT_W'(MIN_OFF);

   sched_state_t     state;
   sched_state_t     next_state;
   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             timer_zero;
   logic             cfg_fire;

   tick_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

   always_comb begin
      next_state = state;
      timer_load = 1'b0;
      timer_val  = ON_VAL;
      case (state)
         IDLE: begin
            // Cooling wins when both requests arrive together.
            if (cool_req) begin
               next_state = COOL;
               timer_load = 1'b1;
            end else if (heat_req) begin
               next_state = HEAT;
               timer_load = 1'b1;
            end
         end
         COOL: begin
            if (timer_zero && (!cool_req || heat_req)) begin
               next_state = REST;
               timer_load = 1'b1;
               timer_val  = OFF_VAL;
            end
         end
         HEAT: begin
            if (timer_zero && (!heat_req || cool_req)) begin
               next_state = REST;
               timer_load = 1'b1;
               timer_val  = OFF_VAL;
            end
         end
         REST: begin
            if (timer_zero) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // cfg_ready is a registered copy of "state is IDLE".
   assign cfg_fire = cfg_valid && cfg_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cooler_on   <= 1'b0;
         heater_on   <= 1'b0;
         cfg_ready   <= 1'b1;
         conflict    <= 1'b0;
         cooldown_th <= COOLDOWN_DEFAULT;
         heatup_th   <= HEATUP_DEFAULT;
      end else begin
         state     <= next_state;
         // Relay drives decoded from next_state so they are registered yet
         // track the state without an extra cycle of lag.
         cooler_on <= (next_state == COOL);
         heater_on <= (next_state == HEAT);
         cfg_ready <= (next_state == IDLE);
         conflict  <= conflict | (cool_req & heat_req);
         if (cfg_fire) begin
            if (cfg_sel) begin
               heatup_th <= clamp_u8(cfg_data, HEATUP_MIN, HEATUP_MAX);
            end else begin
               cooldown_th <= clamp_u8(cfg_data, COOLDOWN_MIN, COOLDOWN_MAX);
            end
         end
      end
   end

endmodule

// File: tb/tb_hvac_actuator_scheduler.sv
// tb/tb_hvac_actuator_scheduler.sv - self-checking bench for hvac_actuator_scheduler
module tb_hvac_actuator_scheduler;

   localparam int MIN_ON  = 8;
   localparam int MIN_OFF = 4;

   logic       clk = 1'b0;
   logic       rst_n, tick, cool_req, heat_req, cfg_valid, cfg_sel;
   logic [7:0] cfg_data;
   logic       cfg_ready, cooler_on, heater_on, conflict;
   logic [7:0] cooldown_th, heatup_th;

   always #5 clk = ~clk;

   hvac_actuator_scheduler #(
      .MIN_ON  (MIN_ON),
      .MIN_OFF (MIN_OFF),
      .CNT_W   (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .cool_req    (cool_req),
      .heat_req    (heat_req),
      .cfg_valid   (cfg_valid),
      .cfg_sel     (cfg_sel),
      .cfg_data    (cfg_data),
      .cfg_ready   (cfg_ready),
      .cooldown_th (cooldown_th),
      .heatup_th   (heatup_th),
      .cooler_on   (cooler_on),
      .heater_on   (heater_on),
      .conflict    (conflict)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int tick_period = 4;

   // Reference model: which relay is driven (0 none, 1 cooler, 2 heater),
   // whether a rest period is running, and how many ticks remain to wait.
   int m_relay, m_wait, m_cd, m_ht;
   bit m_resting, m_conflict;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic model_update();
      bit idle, release_now;
      if (!rst_n) begin
         m_relay = 0; m_resting = 0; m_wait = 0; m_conflict = 0;
         m_cd = 95; m_ht = 60;
         return;
      end
      if (cool_req && heat_req) m_conflict = 1;
      idle = (m_relay == 0) && !m_resting;
      if (cfg_valid && idle) begin
         if (cfg_sel) m_ht = clampi(int'(cfg_data), 10, 80);
         else         m_cd = clampi(int'(cfg_data), 90, 120);
      end
      if (idle) begin
         if (cool_req)      begin m_relay = 1; m_wait = MIN_ON; end
         else if (heat_req) begin m_relay = 2; m_wait = MIN_ON; end
      end else if (m_relay != 0) begin
         release_now = (m_relay == 1) ? (!cool_req || heat_req) : (!heat_req || cool_req);
         if (m_wait == 0 && release_now) begin
            m_relay = 0; m_resting = 1; m_wait = MIN_OFF;
         end else if (tick && m_wait > 0) begin
            m_wait--;
         end
      end else begin
         if (m_wait == 0)   m_resting = 0;
         else if (tick)     m_wait--;
      end
   endtask

   task automatic compare_model();
      chk("model_cooler",   cooler_on,   m_relay == 1);
      chk("model_heater",   heater_on,   m_relay == 2);
      chk("model_ready",    cfg_ready,   (m_relay == 0) && !m_resting);
      chk("model_conflict", conflict,    m_conflict);
      chk("model_cooldown", cooldown_th, m_cd);
      chk("model_heatup",   heatup_th,   m_ht);
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      cyc++;
      compare_model();
   endtask

   task automatic tstep();
      tick = (tick_period != 0) && (cyc % tick_period == 0);
      step();
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!cfg_ready && n < 200) begin tstep(); n++; end
      chk(name, cfg_ready, 1);
   endtask

   typedef struct {
      bit       sel;
      bit [7:0] data;
      int       exp_cd;
      int       exp_ht;
   } cfg_vec_t;

   cfg_vec_t vecs[8];

   initial begin
      int ticks, n;
      vecs[0] = '{0, 8'd130, 120, 60};
      vecs[1] = '{1, 8'd5,   120, 10};
      vecs[2] = '{0, 8'd100, 100, 10};
      vecs[3] = '{0, 8'd0,   90,  10};
      vecs[4] = '{1, 8'd255, 90,  80};
      vecs[5] = '{1, 8'd80,  90,  80};
      vecs[6] = '{0, 8'd90,  90,  80};
      vecs[7] = '{1, 8'd33,  90,  33};

      rst_n = 0; tick = 0; cool_req = 0; heat_req = 0;
      cfg_valid = 0; cfg_sel = 0; cfg_data = 0;
      step(); step();
      chk("rst_cooler", cooler_on, 0);
      chk("rst_heater", heater_on, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_cooldown", cooldown_th, 95);
      chk("rst_heatup", heatup_th, 60);
      chk("rst_ready", cfg_ready, 1);
      rst_n = 1;
      step();

      // Cooling held, then released: on >= MIN_ON ticks, rest >= MIN_OFF ticks.
      cool_req = 1;
      tstep();
      chk("cool_rise", cooler_on, 1);
      chk("cool_ready_low", cfg_ready, 0);
      ticks = 0;
      for (int i = 0; i < 100 && ticks < MIN_ON; i++) begin tstep(); if (tick) ticks++; end
      chk("cool_held_min_on", cooler_on, 1);
      cool_req = 0;
      n = 0;
      while (cooler_on && n < 100) begin tstep(); n++; end
      chk("cool_fall", cooler_on, 0);
      ticks = 0; n = 0;
      while (!cfg_ready && n < 100) begin tstep(); if (tick) ticks++; n++; end
      chk("rest_to_idle", cfg_ready, 1);
      chk("rest_min_off", ticks >= MIN_OFF, 1);

      // Cool -> heat handover always passes through rest.
      cool_req = 1;
      tstep();
      ticks = 0;
      for (int i = 0; i < 50 && ticks < 2; i++) begin tstep(); if (tick) ticks++; end
      cool_req = 0; heat_req = 1;
      n = 0;
      while (cooler_on && n < 100) begin tstep(); n++; end
      chk("handover_cool_off", cooler_on, 0);
      chk("handover_heat_not_yet", heater_on, 0);
      n = 0;
      while (!heater_on && n < 100) begin tstep(); n++; end
      chk("handover_heat_on", heater_on, 1);
      chk("handover_no_conflict", conflict, 0);
      heat_req = 0;
      wait_idle("handover_idle");

      // Simultaneous requests: cooling chosen, conflict sticks.
      cool_req = 1; heat_req = 1;
      tstep();
      chk("both_cool_sel", cooler_on, 1);
      chk("both_heat_off", heater_on, 0);
      chk("both_conflict", conflict, 1);
      cool_req = 0; heat_req = 0;
      wait_idle("both_idle");
      chk("conflict_sticky", conflict, 1);
      rst_n = 0; step(); rst_n = 1;
      chk("conflict_cleared", conflict, 0);

      // Clamped configuration writes from IDLE.
      foreach (vecs[i]) begin
         cfg_valid = 1; cfg_sel = vecs[i].sel; cfg_data = vecs[i].data;
         step();
         cfg_valid = 0;
         chk($sformatf("cfg%0d_cooldown", i), cooldown_th, vecs[i].exp_cd);
         chk($sformatf("cfg%0d_heatup", i), heatup_th, vecs[i].exp_ht);
      end

      // Write attempted while heating is held off until IDLE.
      heat_req = 1;
      tstep();
      chk("heat_on", heater_on, 1);
      cfg_valid = 1; cfg_sel = 0; cfg_data = 8'd110;
      tstep();
      chk("heat_cfg_blocked", cfg_ready, 0);
      chk("heat_cfg_unchanged", cooldown_th, 90);
      heat_req = 0;
      n = 0;
      while (cooldown_th != 8'd110 && n < 200) begin tstep(); n++; end
      chk("held_cfg_landed", cooldown_th, 110);
      chk("held_cfg_heater_off", heater_on, 0);
      cfg_valid = 0;

      // Reset mid-heating.
      heat_req = 1;
      tstep(); tstep();
      chk("pre_rst_heat", heater_on, 1);
      rst_n = 0; heat_req = 0;
      step();
      chk("midrst_heater", heater_on, 0);
      chk("midrst_cooldown", cooldown_th, 95);
      chk("midrst_heatup", heatup_th, 60);
      rst_n = 1;
      step();
      chk("midrst_idle", cfg_ready, 1);

      // No ticks: cooler never times out.
      cool_req = 1;
      tstep();
      cool_req = 0;
      tick_period = 0;
      repeat (200) tstep();
      chk("no_tick_cooler_stuck", cooler_on, 1);
      tick_period = 1;
      wait_idle("no_tick_recover");

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) cool_req = ~cool_req;
         if ($urandom_range(0, 15) == 0) heat_req = ~heat_req;
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_sel   = $urandom_range(0, 1);
         cfg_data  = 8'($urandom_range(0, 255));
         rst_n     = ($urandom_range(0, 399) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
